// File: rtl/drop_sequencer.sv
// drop_sequencer: frame-rate falling-piece FSM (gravity, lock delay, key auto-repeat).
// Define HARD_DROP_EN to add the space-bar hard drop state.
module drop_sequencer #(
  parameter int GRAVITY_FRAMES = 30,
  parameter int LOCK_FRAMES = 15,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       blocked_down,
  input  logic       blocked_left,
  input  logic       blocked_right,
  input  logic       spawn_blocked,
  input  logic       lock_ack,
  output logic       move_left,
  output logic       move_right,
  output logic       move_down,
  output logic       rotate,
  output logic       spawn_req,
  output logic       lock_req,
  output logic [2:0] state,
  output logic       game_over
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, SPAWN = 3'd1, FALL = 3'd2, LOCKING = 3'd3, LOCK_WAIT = 3'd4, GAME_OVER = 3'd5
`ifdef HARD_DROP_EN
    , HARD_DROP = 3'd6
`endif
  } state_t;
  state_t state_q;
  logic [9:0] grav_q, grav_d;
  logic [7:0] rep_q, rep_d, lock_q, lock_d, prev_q;
  logic pend_q, ml_q, mr_q, md_q, rot_q, spawn_q, lockr_q, go_q;
  logic is_l, is_r, is_rot, act_key, fresh, fire, want, lat, tick, down, hd;
  always_comb begin
    is_l = keycode == 8'h04;
    is_r = keycode == 8'h07;
    is_rot = keycode == 8'h1A;
    act_key = is_l || is_r || is_rot;
    fresh = keycode != prev_q;
    fire = act_key && (fresh || rep_q == 8'(REPEAT_FRAMES - 1));
    want = act_key && (fire || pend_q);
`ifdef HARD_DROP_EN
    hd = keycode == 8'h2C && fresh;
`else
    hd = 1'b0;
`endif
    lat = want && !hd;
    rep_d = (!act_key || fire) ? 8'd0 : (rep_q == 8'hFF ? rep_q : rep_q + 8'd1);
    tick = grav_q == 10'(GRAVITY_FRAMES - 1) || keycode == 8'h16;
    down = tick && !blocked_down;
    grav_d = tick ? 10'd0 : (grav_q == 10'h3FF ? grav_q : grav_q + 10'd1);
    lock_d = lock_q == 8'hFF ? lock_q : lock_q + 8'd1;
  end
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      grav_q <= '0;
      rep_q <= '0;
      lock_q <= '0;
      prev_q <= '0;
      pend_q <= 1'b0;
      ml_q <= 1'b0;
      mr_q <= 1'b0;
      md_q <= 1'b0;
      rot_q <= 1'b0;
      spawn_q <= 1'b0;
      lockr_q <= 1'b0;
      go_q <= 1'b0;
    end else begin
      prev_q <= keycode;
      pend_q <= 1'b0;
      rep_q <= '0;
      ml_q <= 1'b0;
      mr_q <= 1'b0;
      md_q <= 1'b0;
      rot_q <= 1'b0;
      spawn_q <= 1'b0;
      case (state_q)
        IDLE: if (keycode == 8'h28) begin
          state_q <= SPAWN;
          spawn_q <= 1'b1;
        end
        SPAWN: begin
          grav_q <= '0;
          state_q <= spawn_blocked ? GAME_OVER : FALL;
          go_q <= spawn_blocked;
        end
        FALL: begin
          rep_q <= rep_d;
          grav_q <= grav_d;
          md_q <= down && !hd;
          // a key action that loses to move_down is replayed next frame
          pend_q <= down && lat;
          ml_q <= !down && lat && is_l && !blocked_left;
          mr_q <= !down && lat && is_r && !blocked_right;
          rot_q <= !down && lat && is_rot;
          if (tick && blocked_down) begin
            state_q <= LOCKING;
            lock_q <= '0;
          end
`ifdef HARD_DROP_EN
          if (hd) state_q <= HARD_DROP;
`endif
        end
        LOCKING: begin
          rep_q <= rep_d;
          ml_q <= lat && is_l && !blocked_left;
          mr_q <= lat && is_r && !blocked_right;
          rot_q <= lat && is_rot;
          if (!blocked_down) begin
            state_q <= FALL;
            grav_q <= '0;
          end else if (lock_q == 8'(LOCK_FRAMES - 1) && !hd) begin
            state_q <= LOCK_WAIT;
            lockr_q <= 1'b1;
            ml_q <= 1'b0;
            mr_q <= 1'b0;
            rot_q <= 1'b0;
          end else lock_q <= lock_d;
`ifdef HARD_DROP_EN
          if (hd) state_q <= HARD_DROP;
`endif
        end
        LOCK_WAIT: if (lock_ack) begin
          state_q <= SPAWN;
          lockr_q <= 1'b0;
          spawn_q <= 1'b1;
        end
        GAME_OVER: if (keycode == 8'h28) begin
          state_q <= IDLE;
          go_q <= 1'b0;
        end
`ifdef HARD_DROP_EN
        HARD_DROP: if (blocked_down) begin
          state_q <= LOCK_WAIT;
          lockr_q <= 1'b1;
        end else md_q <= 1'b1;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign move_left = ml_q;
  assign move_right = mr_q;
  assign move_down = md_q;
  assign rotate = rot_q;
  assign spawn_req = spawn_q;
  assign lock_req = lockr_q;
  assign game_over = go_q;
  assign state = state_q;
endmodule

// File: tb/tb_drop_sequencer.sv
// tb_drop_sequencer: directed scenario tests for drop_sequencer at default parameters.
module tb_drop_sequencer;
  logic frame_clk = 1'b0, Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic blocked_down = 1'b0, blocked_left = 1'b0, blocked_right = 1'b0, spawn_blocked = 1'b0, lock_ack = 1'b0;
  logic ml, mr, md, rot, sp, lr, go;
  logic [2:0] st;
  int nt = 0, nf = 0;
  drop_sequencer dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .blocked_down(blocked_down), .blocked_left(blocked_left), .blocked_right(blocked_right),
    .spawn_blocked(spawn_blocked), .lock_ack(lock_ack),
    .move_left(ml), .move_right(mr), .move_down(md), .rotate(rot),
    .spawn_req(sp), .lock_req(lr), .state(st), .game_over(go)
  );
  always #5 frame_clk = ~frame_clk;
  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask
  task automatic restart();
    Reset = 1'b1;
    {keycode, blocked_down, blocked_left, blocked_right, spawn_blocked, lock_ack} = '0;
    tick();
    Reset = 1'b0;
    keycode = 8'h28;
    tick();
    keycode = 8'h00;
    tick();
  endtask
  task automatic test_reset();
    Reset = 1'b1;
    tick();
    nt++; if ({ml, mr, md, rot, sp, lr, go, st} !== 10'd0) begin nf++; $display("FAIL reset_outs: got %b want 0", {ml, mr, md, rot, sp, lr, go, st}); end
    Reset = 1'b0;
    repeat (3) tick();
    nt++; if (st !== 3'd0) begin nf++; $display("FAIL idle_stays: state=%0d want 0", st); end
  endtask
  task automatic test_spawn();
    keycode = 8'h28;
    tick();
    nt++; if (st !== 3'd1 || sp !== 1'b1) begin nf++; $display("FAIL spawn: state=%0d spawn_req=%b want 1/1", st, sp); end
    keycode = 8'h00;
    tick();
    nt++; if (st !== 3'd2 || sp !== 1'b0) begin nf++; $display("FAIL spawn_fall: state=%0d spawn_req=%b want 2/0", st, sp); end
  endtask
  task automatic test_gravity();
    restart();
    for (int i = 0; i < 90; i++) begin
      tick();
      nt++; if (md !== (i % 30 == 29)) begin nf++; $display("FAIL gravity frame %0d: move_down=%b want %b", i, md, i % 30 == 29); end
    end
  endtask
  task automatic test_left_repeat();
    restart();
    keycode = 8'h04;
    for (int i = 0; i < 20; i++) begin
      tick();
      nt++; if (ml !== (i == 0 || i == 8 || i == 16)) begin nf++; $display("FAIL left_repeat frame %0d: move_left=%b", i, ml); end
    end
    restart();
    blocked_left = 1'b1;
    keycode = 8'h04;
    for (int i = 0; i < 20; i++) begin
      tick();
      nt++; if (ml !== 1'b0) begin nf++; $display("FAIL left_blocked frame %0d: move_left=%b want 0", i, ml); end
    end
  endtask
  task automatic test_rotate_right();
    restart();
    keycode = 8'h1A;
    for (int i = 0; i < 10; i++) begin
      tick();
      nt++; if (rot !== (i == 0 || i == 8)) begin nf++; $display("FAIL rotate frame %0d: rotate=%b", i, rot); end
    end
    keycode = 8'h05;
    tick();
    nt++; if ({ml, mr, md, rot} !== 4'd0) begin nf++; $display("FAIL unlisted_key: moves=%b want 0", {ml, mr, md, rot}); end
    keycode = 8'h07;
    tick();
    nt++; if (mr !== 1'b1) begin nf++; $display("FAIL right: move_right=%b want 1", mr); end
    blocked_right = 1'b1;
    keycode = 8'h00;
    tick();
    keycode = 8'h07;
    tick();
    nt++; if (mr !== 1'b0) begin nf++; $display("FAIL right_blocked: move_right=%b want 0", mr); end
  endtask
  task automatic test_collision();
    restart();
    repeat (29) tick();
    keycode = 8'h04;
    tick();
    nt++; if (md !== 1'b1 || ml !== 1'b0) begin nf++; $display("FAIL collide_down: down=%b left=%b want 1/0", md, ml); end
    tick();
    nt++; if (md !== 1'b0 || ml !== 1'b1) begin nf++; $display("FAIL collide_deferred: down=%b left=%b want 0/1", md, ml); end
    for (int i = 2; i < 9; i++) begin
      tick();
      nt++; if (ml !== (i == 8)) begin nf++; $display("FAIL collide_repeat frame %0d: move_left=%b", i, ml); end
    end
  endtask
  task automatic test_soft_drop();
    restart();
    keycode = 8'h16;
    for (int i = 0; i < 5; i++) begin
      tick();
      nt++; if (md !== 1'b1) begin nf++; $display("FAIL soft_drop frame %0d: move_down=%b want 1", i, md); end
    end
  endtask
  task automatic test_lock();
    restart();
    blocked_down = 1'b1;
    repeat (29) tick();
    nt++; if (st !== 3'd2) begin nf++; $display("FAIL pre_tick: state=%0d want 2", st); end
    tick();
    nt++; if (st !== 3'd3 || md !== 1'b0) begin nf++; $display("FAIL enter_locking: state=%0d down=%b want 3/0", st, md); end
    repeat (5) tick();
    blocked_down = 1'b0;
    tick();
    nt++; if (st !== 3'd2) begin nf++; $display("FAIL unground: state=%0d want 2", st); end
    blocked_down = 1'b1;
    repeat (29) tick();
    nt++; if (st !== 3'd2) begin nf++; $display("FAIL grav_cleared: state=%0d want 2", st); end
    tick();
    nt++; if (st !== 3'd3) begin nf++; $display("FAIL relock: state=%0d want 3", st); end
    keycode = 8'h07;
    tick();
    nt++; if (mr !== 1'b1 || st !== 3'd3) begin nf++; $display("FAIL lock_slide: right=%b state=%0d want 1/3", mr, st); end
    keycode = 8'h00;
    repeat (13) tick();
    nt++; if (st !== 3'd3 || lr !== 1'b0) begin nf++; $display("FAIL lock_delay: state=%0d lock_req=%b want 3/0", st, lr); end
    tick();
    nt++; if (st !== 3'd4 || lr !== 1'b1) begin nf++; $display("FAIL lock_wait: state=%0d lock_req=%b want 4/1", st, lr); end
    keycode = 8'h04;
    repeat (3) tick();
    nt++; if (lr !== 1'b1 || {ml, mr, md, rot} !== 4'd0) begin nf++; $display("FAIL lock_hold: lock_req=%b moves=%b want 1/0", lr, {ml, mr, md, rot}); end
    keycode = 8'h00;
    lock_ack = 1'b1;
    tick();
    nt++; if (st !== 3'd1 || lr !== 1'b0 || sp !== 1'b1) begin nf++; $display("FAIL lock_ack: state=%0d lock_req=%b spawn=%b want 1/0/1", st, lr, sp); end
    blocked_down = 1'b0;
    repeat (2) tick();
    nt++; if (st !== 3'd2 || lr !== 1'b0) begin nf++; $display("FAIL ack_ignored: state=%0d lock_req=%b want 2/0", st, lr); end
    lock_ack = 1'b0;
  endtask
  task automatic test_game_over();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    keycode = 8'h28;
    tick();
    keycode = 8'h00;
    spawn_blocked = 1'b1;
    tick();
    nt++; if (st !== 3'd5 || go !== 1'b1) begin nf++; $display("FAIL game_over: state=%0d game_over=%b want 5/1", st, go); end
    spawn_blocked = 1'b0;
    repeat (2) tick();
    nt++; if (st !== 3'd5 || go !== 1'b1) begin nf++; $display("FAIL game_over_hold: state=%0d game_over=%b want 5/1", st, go); end
    keycode = 8'h28;
    tick();
    keycode = 8'h00;
    nt++; if (st !== 3'd0 || go !== 1'b0) begin nf++; $display("FAIL go_to_idle: state=%0d game_over=%b want 0/0", st, go); end
  endtask
  task automatic test_async_reset();
    restart();
    blocked_down = 1'b1;
    keycode = 8'h16;
    tick();
    keycode = 8'h00;
    repeat (15) tick();
    nt++; if (st !== 3'd4 || lr !== 1'b1) begin nf++; $display("FAIL reach_lock_wait: state=%0d lock_req=%b want 4/1", st, lr); end
    #2 Reset = 1'b1;
    #1;
    nt++; if ({ml, mr, md, rot, sp, lr, go, st} !== 10'd0) begin nf++; $display("FAIL async_reset: got %b want 0", {ml, mr, md, rot, sp, lr, go, st}); end
    tick();
    keycode = 8'h28;
    Reset = 1'b0;
    blocked_down = 1'b0;
    tick();
    nt++; if (st !== 3'd1) begin nf++; $display("FAIL first_frame_idle: state=%0d want 1", st); end
  endtask
  task automatic test_hard_drop();
    int rows = 4, pulses = 0;
    restart();
    keycode = 8'h2C;
`ifdef HARD_DROP_EN
    tick();
    nt++; if (st !== 3'd6) begin nf++; $display("FAIL hard_drop_enter: state=%0d want 6", st); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (md) begin pulses++; rows--; end
      blocked_down = rows == 0;
    end
    nt++; if (pulses != 4) begin nf++; $display("FAIL hard_drop_pulses: got %0d want 4", pulses); end
    nt++; if (st !== 3'd4 || lr !== 1'b1) begin nf++; $display("FAIL hard_drop_lock: state=%0d lock_req=%b want 4/1", st, lr); end
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      if (md) pulses++;
      rows = rows - int'(md);
    end
    nt++; if (st !== 3'd2 || pulses != 0 || rows != 4) begin nf++; $display("FAIL space_ignored: state=%0d pulses=%0d want 2/0", st, pulses); end
`endif
  endtask
  initial begin
    test_reset();
    test_spawn();
    test_gravity();
    test_left_repeat();
    test_rotate_right();
    test_collision();
    test_soft_drop();
    test_lock();
    test_game_over();
    test_async_reset();
    test_hard_drop();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
